pio_event_sequencer: RTL
========================

Name: pio_event_sequencer

Overview:
Hardware service engine for the 10-bit edge-capture PIO (switch/button inputs). It acts as an Avalon-MM master on the PIO slave port and performs the following sequence:
- programs the PIO's irq_mask after reset;
- on PIO irq, reads edge_capture, then clears it;
- expands the captured bits into per-bit event codes and pushes them, lowest index first, into an internal FIFO drained by a valid/ready consumer.

This removes the NIOS interrupt-service path for switch/button events.

Parameters:
- WIDTH, 10, number of PIO input bits; must match the PIO.
- IDX_W, 4, event-code width; must satisfy 2**IDX_W >= WIDTH.
- FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.
- MASK_INIT, {WIDTH{1'b1}}, irq_mask value written after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pio_address  out  2  PIO register address
- pio_chipselect  out  1  PIO select
- pio_write_n  out  1  PIO write strobe, active low
- pio_writedata  out  32  PIO write data
- pio_readdata  in  32  PIO read data, registered in the PIO (1-cycle latency)
- pio_irq  in  1  PIO interrupt, level
- mask_cfg  in  WIDTH  new irq_mask value
- mask_load  in  1  1-cycle pulse; request to write mask_cfg to the PIO
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_code  out  IDX_W  index of the bit that saw an edge
- busy  out  1  FSM not in IDLE

Behaviour:
Interface:
- One clock, clk. Reset is asynchronous and active-high, named reset.

Reset values:
- All outputs 0, except pio_write_n=1.
- FIFO empty; FSM enters INIT_MASK.

FSM states:
- INIT_MASK: 1 cycle; cs=1, write_n=0, addr=2, wdata=MASK_INIT. Next state IDLE.
- IDLE: master outputs idle (cs=0, write_n=1, addr=0). Priority order:
  - pending mask_load, go to CFG_MASK;
  - else pio_irq=1, go to RD_CAP;
  - else stay.
- CFG_MASK: 1 cycle; write addr=2, wdata=latched mask_cfg. Clear pending flag. Next state IDLE.
- RD_CAP: 1 cycle; cs=1, write_n=1, addr=3. Next state RD_WAIT.
- RD_WAIT: 1 cycle; addr held at 3. At the end of this cycle, cap_reg <= pio_readdata[WIDTH-1:0]. Next state CLR.
- CLR: 1 cycle; write addr=3, wdata=cap_reg. Next state DISPATCH, or IDLE if cap_reg==0 (spurious irq).
- DISPATCH, once per cycle while cap_reg!=0:
  - If the FIFO is not full (or a pop occurs this cycle), push the index of the lowest set bit and clear that bit.
  - If the FIFO is full with no pop, stall with no push.
  - When cap_reg==0, go to IDLE.

mask_load handling:
- Latched into a pending flag plus mask register in any state.
- A second pulse before service overwrites the latched value; only one write results.

Timing:
- Minimum latency from irq high in IDLE to first evt_valid is 5 cycles (IDLE→RD_CAP→RD_WAIT→CLR→DISPATCH push, visible next cycle).
- irq is sampled only in IDLE. The PIO irq drops 1 cycle after CLR.

FIFO:
- Push and pop in the same cycle are both allowed, including when full.
- Empty: evt_valid=0 and evt_code holds its last value.
- Pointers wrap modulo FIFO_DEPTH.
- Events are never dropped; back-pressure stalls DISPATCH, and further edges accumulate in the PIO.

Known limitation:
- The PIO clears all capture bits on any write. An edge arriving between RD_CAP and CLR on a bit not in cap_reg is lost. Software-visible; no fix required.

Reset mid-operation:
- Any state returns to INIT_MASK; FIFO is flushed; pending mask_load is discarded.

Optional Feature:
PIO_SEQ_TIMESTAMP_EN:
- Defined:
  - adds a 16-bit free-running cycle counter (reset 0, wraps 0xFFFF→0);
  - adds output evt_time[15:0];
  - the counter value sampled in RD_WAIT is stored with every event from that capture, so all events from one capture share a timestamp.
- Undefined: no counter, no evt_time port; FIFO stores IDX_W bits only.

Decomposition:
- Package pio_seq_pkg:
  - state enum (INIT_MASK, IDLE, CFG_MASK, RD_CAP, RD_WAIT, CLR, DISPATCH);
  - PIO address constants ADDR_DATA=2'd0, ADDR_MASK=2'd2, ADDR_EDGE=2'd3;
  - TS_W=16.
- Sub-module pio_evt_fifo: parameterised synchronous FIFO (data width, depth) with full/empty and simultaneous push/pop. The lowest-set-bit priority encoder stays inline.

Test Plan:
1. Reset release → one write, addr=2 wdata=0x3FF, in the first cycle; then IDLE with busy=0.
2. PIO model captures bits 0x205 and raises irq, evt_ready=1 → read addr 3, write addr 3 wdata=0x205, evt_code sequence 0, 2, 9; first evt_valid 5 cycles after irq.
3. FIFO_DEPTH=8, evt_ready=0, capture 0x3FF → 8 events queued, busy=1 stalled in DISPATCH; raise evt_ready → codes 8, 9 follow, no loss.
4. mask_load with mask_cfg=0x00F while in DISPATCH → exactly one write addr=2 wdata=0x00F after return to IDLE, before servicing a pending irq.
5. irq with readdata=0 → CLR then IDLE, no events pushed.
6. Assert reset during DISPATCH with 3 events queued → evt_valid=0 immediately, INIT_MASK write follows release; with PIO_SEQ_TIMESTAMP_EN, events of one capture carry identical evt_time.

Source files
------------

// File: rtl/pio_event_sequencer_pkg.sv
// pio_seq_pkg: shared types and constants for the PIO event sequencer.
// Holds the sequencer state encoding, the PIO register map and the timestamp width.
// Build option PIO_SEQ_TIMESTAMP_EN (see pio_event_sequencer.sv) relies on TS_W.
package pio_seq_pkg;

    typedef enum logic [2:0] {
        INIT_MASK = 3'd0,
        IDLE      = 3'd1,
        CFG_MASK  = 3'd2,
        RD_CAP    = 3'd3,
        RD_WAIT   = 3'd4,
        CLR       = 3'd5,
        DISPATCH  = 3'd6
    } seq_state_t;

    // PIO slave register map.
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int TS_W = 16;

endpackage

// File: rtl/pio_event_sequencer_if.sv
// pio_event_sequencer_if: PIO Avalon-MM master bus, mask config and event stream.
// master = sequencer side, slave = PIO/consumer side. Ports: pio_* bus, mask_cfg/mask_load,
// evt_valid/evt_ready/evt_code, busy, and evt_time when PIO_SEQ_TIMESTAMP_EN is defined.
interface pio_event_sequencer_if #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4
);
    import pio_seq_pkg::*;

    logic [1:0]       pio_address;
    logic             pio_chipselect;
    logic             pio_write_n;
    logic [31:0]      pio_writedata;
    logic [31:0]      pio_readdata;
    logic             pio_irq;
    logic [WIDTH-1:0] mask_cfg;
    logic             mask_load;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_code;
    logic             busy;
`ifdef PIO_SEQ_TIMESTAMP_EN
    logic [TS_W-1:0]  evt_time;
`endif

    modport master (
`ifdef PIO_SEQ_TIMESTAMP_EN
        output evt_time,
`endif
        output pio_address, pio_chipselect, pio_write_n, pio_writedata,
        input  pio_readdata, pio_irq,
        input  mask_cfg, mask_load,
        output evt_valid, evt_code, busy,
        input  evt_ready
    );

    modport slave (
`ifdef PIO_SEQ_TIMESTAMP_EN
        input  evt_time,
`endif
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
        output pio_readdata, pio_irq,
        output mask_cfg, mask_load,
        input  evt_valid, evt_code, busy,
        output evt_ready
    );

endinterface

// File: rtl/pio_event_sequencer_fifo.sv
// pio_evt_fifo: synchronous FIFO, DW bits x DEPTH entries (DEPTH power of two, >= 2).
// Latency: pushed word visible on dout the cycle after push; push+pop allowed together, even when full.
// Backpressure: push ignored when full without a pop; dout holds the last popped word while empty.
module pio_evt_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [DW-1:0] hold_q;
    logic          push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // When full, a same-cycle pop frees the slot being written.
    assign push_ok = push && (!full || pop_ok);

    assign dout = empty ? hold_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pio_event_sequencer.sv
// pio_event_sequencer: services an edge-capture PIO as Avalon-MM master and turns captures into events.
// Latency: irq seen in IDLE -> first evt_valid 5 cycles later; one event pushed per DISPATCH cycle.
// Backpressure: full event FIFO stalls DISPATCH; new edges accumulate in the PIO. Option: PIO_SEQ_TIMESTAMP_EN.
// Ports: clk, reset (async, active high), bus (pio_event_sequencer_if.master).
module pio_event_sequencer
    import pio_seq_pkg::*;
#(
    parameter int               WIDTH      = 10,
    parameter int               IDX_W      = 4,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [WIDTH-1:0] MASK_INIT  = '1
) (
    input  logic                   clk,
    input  logic                   reset,
    pio_event_sequencer_if.master  bus
);

`ifdef PIO_SEQ_TIMESTAMP_EN
    localparam int DW = TS_W + IDX_W;
`else
    localparam int DW = IDX_W;
`endif

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] mask_q;
    logic             pend_q;
    logic [IDX_W-1:0] low_idx;

    logic [1:0]       addr_c;
    logic             cs_c, wn_c, busy_c;
    logic [31:0]      wd_c;

    logic             fifo_full, fifo_empty, push, pop;
    logic [DW-1:0]    fifo_din, fifo_dout;

    // Upper readdata bits are outside the PIO width.
    logic             unused_rd;
    assign unused_rd = ^bus.pio_readdata[31:WIDTH];

    // Lowest set bit of the remaining capture.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (cap_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign pop  = !fifo_empty && bus.evt_ready;
    assign push = (state_q == DISPATCH) && (cap_q != '0) && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT_MASK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_c  = ADDR_DATA;
        cs_c    = 1'b0;
        wn_c    = 1'b1;
        wd_c    = '0;
        busy_c  = (state_q != IDLE);
        unique case (state_q)
            INIT_MASK: begin
                cs_c    = 1'b1;
                wn_c    = 1'b0;
                addr_c  = ADDR_MASK;
                wd_c    = 32'(MASK_INIT);
                state_d = IDLE;
            end
            IDLE: begin
                // Config writes win over irq service so a new mask applies first.
                if (pend_q) begin
                    state_d = CFG_MASK;
                end else if (bus.pio_irq) begin
                    state_d = RD_CAP;
                end
            end
            CFG_MASK: begin
                cs_c    = 1'b1;
                wn_c    = 1'b0;
                addr_c  = ADDR_MASK;
                wd_c    = 32'(mask_q);
                state_d = IDLE;
            end
            RD_CAP: begin
                cs_c    = 1'b1;
                addr_c  = ADDR_EDGE;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Read data from RD_CAP arrives this cycle; no second read issued.
                addr_c  = ADDR_EDGE;
                state_d = CLR;
            end
            CLR: begin
                cs_c    = 1'b1;
                wn_c    = 1'b0;
                addr_c  = ADDR_EDGE;
                wd_c    = 32'(cap_q);
                state_d = (cap_q == '0) ? IDLE : DISPATCH;
            end
            DISPATCH: begin
                if (cap_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT_MASK;
        endcase
        // The state register already sits in INIT_MASK during reset; keep the bus
        // quiet until release so the init write happens exactly once afterwards.
        if (reset) begin
            cs_c   = 1'b0;
            wn_c   = 1'b1;
            addr_c = ADDR_DATA;
            wd_c   = '0;
            busy_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q  <= '0;
            mask_q <= '0;
            pend_q <= 1'b0;
        end else begin
            if (state_q == RD_WAIT) begin
                cap_q <= bus.pio_readdata[WIDTH-1:0];
            end else if (push) begin
                cap_q <= cap_q & (cap_q - 1'b1);
            end
            // A pulse landing in CFG_MASK keeps the request pending for another write.
            if (bus.mask_load) begin
                pend_q <= 1'b1;
                mask_q <= bus.mask_cfg;
            end else if (state_q == CFG_MASK) begin
                pend_q <= 1'b0;
            end
        end
    end

`ifdef PIO_SEQ_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt, ts_cap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_cap <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (state_q == RD_WAIT) begin
                ts_cap <= ts_cnt;
            end
        end
    end

    assign fifo_din     = {ts_cap, low_idx};
    assign bus.evt_time = fifo_dout[DW-1:IDX_W];
`else
    assign fifo_din = low_idx;
`endif

    pio_evt_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.pio_address    = addr_c;
    assign bus.pio_chipselect = cs_c;
    assign bus.pio_write_n    = wn_c;
    assign bus.pio_writedata  = wd_c;
    assign bus.busy           = busy_c;
    assign bus.evt_valid      = !fifo_empty;
    assign bus.evt_code       = fifo_dout[IDX_W-1:0];

endmodule
